branch_target_buffer: RTL and testbench

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

---
 rtl/branch_target_buffer.sv | 95 +++++++++
 tb/tb_branch_target_buffer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: zero-latency fetch lookup, single-entry
// training from execute, 2-bit saturating direction counter per entry.
module branch_target_buffer #(
    parameter int BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        predicted_taken,
    output logic [31:0] predicted_target,
    input  logic        update_btb,
    input  logic [31:0] ex_pc,
    input  logic [31:0] calc_jump_addr,
    input  logic        branch_taken
);

    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    logic             valid_q  [BTB_ENTRIES];
    logic [TAG_W-1:0] tag_q    [BTB_ENTRIES];
    logic [31:0]      target_q [BTB_ENTRIES];
    logic [1:0]       ctr_q    [BTB_ENTRIES];

    logic [IDX-1:0]   lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;

    logic [IDX-1:0]   upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             wr_en;
    logic             wr_data;
    logic [1:0]       ctr_d;

    logic             unused_pc_lsbs;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == CTR_ST) ? CTR_ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
    endfunction

    assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

    // Lookup reads registered state only, so a same-cycle update is not seen.
    always_comb begin
        lk_idx           = if_pc[IDX+1:2];
        lk_tag           = if_pc[31:IDX+2];
        lk_hit           = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        predicted_taken  = lk_hit && ctr_q[lk_idx][1];
        predicted_target = predicted_taken ? target_q[lk_idx] : 32'h0;
    end

    always_comb begin
        upd_idx = ex_pc[IDX+1:2];
        upd_tag = ex_pc[31:IDX+2];
        upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        // A not-taken miss trains nothing; only hits or taken misses write.
        wr_en   = update_btb && (upd_hit || branch_taken);
        wr_data = wr_en && branch_taken;
        ctr_d   = CTR_WT;
        if (upd_hit) begin
            ctr_d = branch_taken ? ctr_inc(ctr_q[upd_idx]) : ctr_dec(ctr_q[upd_idx]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WNT;
            end
        end else if (wr_en) begin
            valid_q[upd_idx] <= 1'b1;
            ctr_q[upd_idx]   <= ctr_d;
        end
    end

    // Tag/target carry no reset; they are qualified by valid_q.
    always_ff @(posedge clk) begin
        if (!rst && wr_data) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= calc_jump_addr;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: directed scenarios then random
// traffic, checked against an entry-level behavioural model.
module tb_branch_target_buffer;

    localparam int N    = 16;
    localparam int IDXW = $clog2(N);

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic        predicted_taken;
    logic [31:0] predicted_target;
    logic        update_btb;
    logic [31:0] ex_pc;
    logic [31:0] calc_jump_addr;
    logic        branch_taken;

    branch_target_buffer #(.BTB_ENTRIES(N)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_pc            (if_pc),
        .predicted_taken  (predicted_taken),
        .predicted_target (predicted_target),
        .update_btb       (update_btb),
        .ex_pc            (ex_pc),
        .calc_jump_addr   (calc_jump_addr),
        .branch_taken     (branch_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tgt;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: one record per slot, counter as plain integer 0..3.
    bit          m_valid [N];
    int unsigned m_tag   [N];
    int unsigned m_tgt   [N];
    int          m_ctr   [N];
    bit          model_known = 0;

    function automatic int slot(input int unsigned pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic int unsigned tagof(input int unsigned pc);
        return pc >> (IDXW + 2);
    endfunction

    task automatic step(input bit r, input int unsigned lpc, input bit upd,
                        input int unsigned epc, input int unsigned addr,
                        input bit tk, input string name);
        exp_t e;
        int   s;
        bit   h;
        @(posedge clk);
        #1;
        rst            = r;
        if_pc          = lpc;
        update_btb     = upd;
        ex_pc          = epc;
        calc_jump_addr = addr;
        branch_taken   = tk;
        if (model_known) begin
            s      = slot(lpc);
            h      = m_valid[s] && (m_tag[s] == tagof(lpc));
            e.pc   = lpc;
            e.tk   = h && (m_ctr[s] >= 2);
            e.tgt  = e.tk ? m_tgt[s] : 32'h0;
            e.name = name;
            exp_q.push_back(e);
        end
        if (r) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 0;
                m_ctr[i]   = 1;
            end
            model_known = 1;
        end else if (upd) begin
            s = slot(epc);
            h = m_valid[s] && (m_tag[s] == tagof(epc));
            if (h) begin
                m_ctr[s] = tk ? ((m_ctr[s] < 3) ? m_ctr[s] + 1 : 3)
                              : ((m_ctr[s] > 0) ? m_ctr[s] - 1 : 0);
                if (tk) m_tgt[s] = addr;
            end else if (tk) begin
                m_valid[s] = 1;
                m_tag[s]   = tagof(epc);
                m_tgt[s]   = addr;
                m_ctr[s]   = 2;
            end
        end
    endtask

    task automatic look(input int unsigned lpc, input string name);
        step(0, lpc, 0, 32'h0, 32'h0, 0, name);
    endtask

    // Monitor: the DUT presents a lookup result every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (predicted_taken !== e.tk || predicted_target !== e.tgt) begin
                    bad++;
                    $display("FAIL %s pc=%h got taken=%b target=%h want taken=%b target=%h",
                             e.name, e.pc, predicted_taken, predicted_target, e.tk, e.tgt);
                end
            end
        end
    end

    initial begin
        int unsigned pc_a, pc_b, lpc, tg, ix;
        rst = 1'b1; if_pc = '0; update_btb = 1'b0; ex_pc = '0;
        calc_jump_addr = '0; branch_taken = 1'b0;

        step(1, 32'h100, 0, 0, 0, 0, "reset");
        step(1, 32'h100, 0, 0, 0, 0, "reset_hold");
        look(32'h100, "cold_start");
        look(32'h2C4, "cold_other");

        step(0, 32'h100, 1, 32'h100, 32'h200, 1, "alloc_same_cycle");
        look(32'h100, "alloc_hit");
        look(32'h103, "alloc_lsb_ignored");

        step(0, 32'h100, 1, 32'h100, 32'h999, 0, "hyst_nt1");
        look(32'h100, "hyst_wnt");
        step(0, 32'h100, 1, 32'h100, 32'h0, 0, "hyst_nt2");
        step(0, 32'h100, 1, 32'h100, 32'h0, 0, "hyst_nt3");
        look(32'h100, "hyst_snt");
        step(0, 32'h100, 1, 32'h100, 32'h200, 1, "hyst_t1");
        look(32'h100, "hyst_wnt_again");
        step(0, 32'h100, 1, 32'h100, 32'h200, 1, "hyst_t2");
        step(0, 32'h100, 1, 32'h100, 32'h200, 1, "hyst_t3");
        look(32'h100, "hyst_st");
        step(0, 32'h100, 1, 32'h100, 32'h0, 0, "hyst_st_nt");
        look(32'h100, "hyst_wt_from_st");

        look(32'h140, "alias_miss");
        step(0, 32'h140, 1, 32'h140, 32'h300, 1, "alias_replace");
        look(32'h100, "alias_old_miss");
        look(32'h140, "alias_new_hit");

        step(0, 32'h100, 1, 32'h100, 32'h200, 1, "wnt_alloc");
        step(0, 32'h100, 1, 32'h100, 32'h200, 0, "wnt_down");
        step(0, 32'h100, 1, 32'h100, 32'h200, 1, "same_cycle_wnt");
        look(32'h100, "same_cycle_next");

        step(0, 32'h100, 1, 32'h180, 32'h500, 0, "nt_miss_no_alloc");
        look(32'h180, "nt_miss_check");
        step(0, 32'h100, 0, 32'h100, 32'h700, 1, "upd_off");
        look(32'h100, "upd_off_check");

        step(1, 32'h100, 1, 32'h100, 32'h200, 1, "rst_priority");
        look(32'h100, "rst_priority_next");
        look(32'h140, "rst_cleared");

        for (int n = 0; n < 600; n++) begin
            tg = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) tg = $urandom >> (IDXW + 2);
            ix   = $urandom_range(0, N - 1);
            pc_a = (tg << (IDXW + 2)) | (ix << 2) | $urandom_range(0, 3);
            tg   = $urandom_range(0, 3);
            ix   = $urandom_range(0, N - 1);
            pc_b = (tg << (IDXW + 2)) | (ix << 2) | $urandom_range(0, 3);
            lpc  = ($urandom_range(0, 2) == 0) ? pc_a : pc_b;
            step(($urandom_range(0, 59) == 0), lpc, ($urandom_range(0, 3) != 0),
                 pc_a, $urandom, ($urandom_range(0, 2) != 0), "random");
        end

        repeat (2) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d want pending=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
